chooser_table_update: RTL and testbench
=======================================

Name: chooser_table_update

Overview:
- Hybrid-predictor chooser table. Holds one saturating selector counter per PC index.
- Supplies `chooser` to the hybrid prediction mux at fetch.
- Consumes the delayed chooser snapshot and BATAGE/BFNP predictions from the chooser shift register at branch resolution, and writes back the trained counter.
- Sits between the resolve stage and the fetch-side mux. A reset-time sweep FSM initialises every entry.

Parameters:
- WIDTH_COUNTER, 2, chooser counter width in bits.
- IDX_W, 14, index width; table depth = 2**IDX_W.
- INIT_VAL, 3, value written to every entry by the init sweep; also the chooser output while not ready.
- CNT_MAX, 3, upper saturation bound (counts toward BFNP).
- CNT_MIN, 0, lower saturation bound (counts toward BATAGE).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  fetch stall; holds `chooser` and the read index.
- pc_fetch  in  32  fetch PC ([32:1] numbering).
- chooser  out  WIDTH_COUNTER  registered counter for pc_fetch, to the hybrid mux.
- upd_valid  in  1  a resolved conditional branch is presented this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_counter  in  WIDTH_COUNTER  chooser snapshot captured at prediction time.
- upd_taken  in  1  actual branch direction.
- upd_pred_batage  in  1  BATAGE prediction at prediction time.
- upd_pred_bfnp  in  1  BFNP prediction at prediction time.
- ready  out  1  init sweep complete; table in service.
- bfnp_wins  out  32  count of trainings where only BFNP was correct.
- batage_wins  out  32  count of trainings where only BATAGE was correct.

Behaviour:
- Index: bits [IDX_W+2:3] of the PC in [32:1] numbering (byte-address bits IDX_W+1..2). The same mapping applies to pc_fetch and upd_pc.
- FSM states:
  - INIT: entered on rst, from any state; rst mid-sweep restarts at 0. One entry per cycle receives INIT_VAL, sweep pointer 0..2**IDX_W-1. When the pointer reaches the last entry → RUN next cycle. Duration is exactly 2**IDX_W cycles after rst deasserts.
  - RUN: normal operation. Stays here until rst.
- Reset values:
  - chooser = INIT_VAL, ready = 0, bfnp_wins = 0, batage_wins = 0, sweep pointer = 0.
- In INIT:
  - upd_valid is ignored: no write, no statistics.
  - chooser holds INIT_VAL.
- Read path, RUN, stall=0:
  - chooser <= table[idx(pc_fetch)]; 1-cycle latency.
  - stall=1: chooser holds its value.
- Training, RUN, upd_valid=1. new is computed from upd_counter, not from the table:
  - upd_pred_bfnp != upd_pred_batage and upd_taken == upd_pred_bfnp: new = min(upd_counter+1, CNT_MAX); bfnp_wins++.
  - upd_pred_bfnp != upd_pred_batage and upd_taken == upd_pred_batage: new = max(upd_counter-1, CNT_MIN); batage_wins++.
  - predictions equal: no write, no statistic change.
  - Write table[idx(upd_pc)] <= new at the same posedge.
- Write/read collision: when a write and a non-stalled read target the same index in the same cycle, chooser takes the newly written value (bypass).
- Statistic counters wrap modulo 2**32.
- Arithmetic is unsigned in WIDTH_COUNTER bits; saturation means no wrap at either bound.

Decomposition:
- Shared package holds:
  - chooser_cnt_t typedef (WIDTH_COUNTER bits)
  - chooser_state_e enum {INIT, RUN}
  - function chooser_index(pc)
  - function chooser_train(cnt, taken, p_batage, p_bfnp) returning {write_en, new_cnt, which_won}
- Sub-module chooser_ram: single-clock, one write and one registered read port, write-first bypass. Depth and width are parameters.

Test Plan:
- Reset sweep, IDX_W=4: pulse rst 1 cycle → ready=0 for exactly 16 cycles then 1. Read every index → chooser=3.
- Assert rst at sweep step 7 → pointer restarts. ready rises 16 cycles after the second rst deasserts.
- BFNP-only correct: upd_counter=1, taken=1, bfnp=1, batage=0 → entry becomes 2, bfnp_wins=1. Repeat with upd_counter=3 → stays 3.
- BATAGE-only correct: upd_counter=0, taken=0, batage=0, bfnp=1 → stays 0, batage_wins=1. Agreeing predictions → no write, counters unchanged.
- Same-cycle write and read to index 5 (stall=0) → chooser shows new value next cycle. With stall=1 → chooser keeps the old value.
- upd_valid=1 during INIT → table unchanged, both statistic counters remain 0.

Source files
------------

// File: rtl/chooser_table_update_pkg.sv
// Shared types and helpers for the hybrid-predictor chooser table.
// Index mapping and counter training rules live here.
package chooser_table_update_pkg;

  localparam int CHOOSER_W = 2;

  typedef logic [CHOOSER_W-1:0] chooser_cnt_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } chooser_state_e;

  typedef struct packed {
    logic         we;
    chooser_cnt_t cnt;
    logic         bfnp_won;
  } chooser_train_t;

  // Word index of a byte PC; callers keep the low IDX_W bits.
  function automatic logic [29:0] chooser_index(
    input logic [31:0] pc
  );
    return pc[31:2];
  endfunction

  function automatic chooser_train_t chooser_train(
    input chooser_cnt_t cnt,
    input logic         taken,
    input logic         p_batage,
    input logic         p_bfnp,
    input chooser_cnt_t cmax,
    input chooser_cnt_t cmin
  );
    chooser_train_t t;
    t.we       = p_batage != p_bfnp;
    t.bfnp_won = taken == p_bfnp;
    if (t.bfnp_won)
      t.cnt = (cnt >= cmax) ? cmax : cnt + 1'b1;
    else
      t.cnt = (cnt <= cmin) ? cmin : cnt - 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/chooser_table_update_ram.sv
// Single-clock table RAM: one write port, one registered read
// port with enable, write-first bypass on same-address access.
module chooser_table_update_ram #(
  parameter int              WIDTH      = 2,
  parameter int              DEPTH_LOG2 = 14,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;
  logic             w_hit;

  assign w_hit   = i_we && (i_waddr == i_raddr);
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rdata <= RST_VAL;
    else if (i_re)
      r_rdata <= w_hit ? i_wdata : r_mem[i_raddr];
  end

endmodule

// File: rtl/chooser_table_update.sv
// Chooser table: per-PC saturating selector between BATAGE and BFNP,
// initialised by a reset sweep and trained at branch resolution.
module chooser_table_update
  import chooser_table_update_pkg::*;
#(
  parameter int WIDTH_COUNTER = CHOOSER_W,
  parameter int IDX_W         = 14,
  parameter int INIT_VAL      = 3,
  parameter int CNT_MAX       = 3,
  parameter int CNT_MIN       = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_stall,
  input  logic [31:0]              i_pc_fetch,
  output logic [WIDTH_COUNTER-1:0] o_chooser,
  input  logic                     i_upd_valid,
  input  logic [31:0]              i_upd_pc,
  input  logic [WIDTH_COUNTER-1:0] i_upd_counter,
  input  logic                     i_upd_taken,
  input  logic                     i_upd_pred_batage,
  input  logic                     i_upd_pred_bfnp,
  output logic                     o_ready,
  output logic [31:0]              o_bfnp_wins,
  output logic [31:0]              o_batage_wins
);

  localparam logic [IDX_W-1:0] LAST = '1;
  localparam logic [WIDTH_COUNTER-1:0] INIT_C = WIDTH_COUNTER'(INIT_VAL);
  localparam chooser_cnt_t MAX_C = CHOOSER_W'(CNT_MAX);
  localparam chooser_cnt_t MIN_C = CHOOSER_W'(CNT_MIN);

  chooser_state_e r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      r_bfnp_wins;
  logic [31:0]      r_batage_wins;

  logic [29:0]              w_fidx_full;
  logic [29:0]              w_uidx_full;
  logic [IDX_W-1:0]         w_fidx;
  logic [IDX_W-1:0]         w_uidx;
  chooser_train_t           w_train;
  logic                     w_init;
  logic                     w_upd;
  logic                     w_we;
  logic [IDX_W-1:0]         w_waddr;
  logic [WIDTH_COUNTER-1:0] w_wdata;
  logic                     w_re;
  logic                     w_unused;

  assign w_fidx_full = chooser_index(i_pc_fetch);
  assign w_uidx_full = chooser_index(i_upd_pc);
  assign w_fidx      = w_fidx_full[IDX_W-1:0];
  assign w_uidx      = w_uidx_full[IDX_W-1:0];
  assign w_unused    = ^{w_fidx_full, w_uidx_full,
                         i_pc_fetch[1:0], i_upd_pc[1:0]};

  assign w_train = chooser_train(chooser_cnt_t'(i_upd_counter),
                                 i_upd_taken, i_upd_pred_batage,
                                 i_upd_pred_bfnp, MAX_C, MIN_C);

  assign w_init  = (r_state == INIT) && !i_rst;
  assign w_upd   = (r_state == RUN) && !i_rst &&
                   i_upd_valid && w_train.we;
  assign w_we    = w_init || w_upd;
  assign w_waddr = w_init ? r_ptr : w_uidx;
  assign w_wdata = w_init ? INIT_C : WIDTH_COUNTER'(w_train.cnt);
  assign w_re    = (r_state == RUN) && !i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else if (r_state == INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == LAST)
        r_state <= RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bfnp_wins   <= '0;
      r_batage_wins <= '0;
    end else if (w_upd) begin
      if (w_train.bfnp_won)
        r_bfnp_wins <= r_bfnp_wins + 32'd1;
      else
        r_batage_wins <= r_batage_wins + 32'd1;
    end
  end

  // Read register resets to INIT_VAL and is frozen until RUN.
  chooser_table_update_ram #(
    .WIDTH      (WIDTH_COUNTER),
    .DEPTH_LOG2 (IDX_W),
    .RST_VAL    (INIT_C)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_fidx),
    .o_rdata (o_chooser)
  );

  assign o_ready       = (r_state == RUN);
  assign o_bfnp_wins   = r_bfnp_wins;
  assign o_batage_wins = r_batage_wins;

endmodule

// File: tb/tb_chooser_table_update.sv
// Bench for the chooser table with a 16-entry configuration,
// compared each cycle against an array-based behavioural model.
module tb_chooser_table_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] pc_fetch = '0;
  logic [1:0]  chooser;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [1:0]  upd_counter = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_batage = 1'b0;
  logic        upd_pred_bfnp = 1'b0;
  logic        ready;
  logic [31:0] bfnp_wins;
  logic [31:0] batage_wins;

  int vectors = 0;
  int miscompares = 0;

  int          m_tab [16];
  int          m_ch = 3;
  int          m_cyc = 0;
  bit          m_ready = 0;
  logic [31:0] m_bw = '0;
  logic [31:0] m_aw = '0;

  chooser_table_update #(
    .WIDTH_COUNTER (2),
    .IDX_W         (4),
    .INIT_VAL      (3),
    .CNT_MAX       (3),
    .CNT_MIN       (0)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_pc_fetch        (pc_fetch),
    .o_chooser         (chooser),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_counter     (upd_counter),
    .i_upd_taken       (upd_taken),
    .i_upd_pred_batage (upd_pred_batage),
    .i_upd_pred_bfnp   (upd_pred_bfnp),
    .o_ready           (ready),
    .o_bfnp_wins       (bfnp_wins),
    .o_batage_wins     (batage_wins)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, then compare the DUT.
  task automatic tick();
    int c;
    if (rst) begin
      m_cyc = 0;
      m_ready = 0;
      m_ch = 3;
      m_bw = '0;
      m_aw = '0;
    end else if (!m_ready) begin
      m_cyc++;
      if (m_cyc == 16) begin
        m_ready = 1;
        foreach (m_tab[i]) m_tab[i] = 3;
      end
    end else begin
      if (upd_valid && upd_pred_bfnp != upd_pred_batage) begin
        c = int'(upd_counter);
        if (upd_taken == upd_pred_bfnp) begin
          m_tab[idx(upd_pc)] = (c + 1 > 3) ? 3 : c + 1;
          m_bw++;
        end else begin
          m_tab[idx(upd_pc)] = (c - 1 < 0) ? 0 : c - 1;
          m_aw++;
        end
      end
      if (!stall) m_ch = m_tab[idx(pc_fetch)];
    end
    @(posedge clk);
    #1;
    check("ready", 32'(ready), 32'(m_ready));
    check("chooser", 32'(chooser), 32'(m_ch));
    check("bfnp_wins", bfnp_wins, m_bw);
    check("batage_wins", batage_wins, m_aw);
  endtask

  task automatic upd(input int i, input int cnt,
                     input bit tk, input bit pb, input bit pf);
    upd_valid = 1'b1;
    upd_pc = 32'(i) << 2;
    upd_counter = 2'(cnt);
    upd_taken = tk;
    upd_pred_batage = pb;
    upd_pred_bfnp = pf;
  endtask

  task automatic read(input int i);
    upd_valid = 1'b0;
    pc_fetch = 32'(i) << 2;
    tick();
    tick();
  endtask

  initial begin
    // reset, then a second reset at sweep step 7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("ready_low_sweep", 32'(ready), 32'd0);
      tick();
    end
    check("ready_after_16", 32'(ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pc_fetch = 32'(i) << 2;
      tick();
      check("init_val", 32'(chooser), 32'd3);
    end

    // BFNP-only correct
    upd(9, 1, 1, 0, 1);
    tick();
    read(9);
    check("bfnp_inc", 32'(chooser), 32'd2);
    check("bfnp_cnt", bfnp_wins, 32'd1);
    upd(9, 3, 1, 0, 1);
    tick();
    read(9);
    check("bfnp_sat", 32'(chooser), 32'd3);

    // BATAGE-only correct, then agreeing predictions
    upd(10, 0, 0, 0, 1);
    tick();
    read(10);
    check("batage_sat", 32'(chooser), 32'd0);
    check("batage_cnt", batage_wins, 32'd1);
    upd(10, 2, 1, 1, 1);
    tick();
    read(10);
    check("agree_nowrite", 32'(chooser), 32'd0);
    check("agree_bfnp", bfnp_wins, 32'd2);

    // same-cycle write/read to index 5
    upd(5, 1, 0, 0, 1);
    pc_fetch = 32'(5) << 2;
    stall = 1'b0;
    tick();
    check("bypass", 32'(chooser), 32'd0);
    upd(5, 0, 1, 0, 1);
    stall = 1'b1;
    tick();
    check("stall_hold", 32'(chooser), 32'd0);
    stall = 1'b0;
    read(5);
    check("stall_written", 32'(chooser), 32'd1);

    // updates during INIT are ignored
    rst = 1'b1;
    upd_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      upd(2, 0, 0, 0, 1);
      tick();
    end
    read(2);
    check("init_upd_tab", 32'(chooser), 32'd3);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 3) == 0);
      pc_fetch = $urandom;
      upd_valid = $urandom_range(0, 1) == 1;
      upd_pc = ($urandom_range(0, 1) == 1) ? pc_fetch : $urandom;
      upd_counter = 2'($urandom_range(0, 3));
      upd_taken = 1'($urandom);
      upd_pred_batage = 1'($urandom);
      upd_pred_bfnp = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
